median_row_packer: RTL and testbench

- Upstream feeder for the median-filter run stage.
- Accepts a raster stream of 8-bit pixels and packs every 4 pixels into a 32-bit word.
- Buffers the two previous rows, so each output is a column-aligned triple word0/word1/word2 = rows r-2 / r-1 / r.
- Those three words drive the run stage's 32-bit row inputs (arg_1/arg_2/arg_3 wires), with a valid/ready handshake and a frame-last flag.

---
 rtl/median_row_packer_if.sv | 24 ++
 rtl/median_row_packer.sv | 127 ++++++++++++
 tb/tb_median_row_packer.sv | 351 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/median_row_packer_if.sv
// Pixel-in / row-triple-out bundle for median_row_packer.
// The slave modport is the packer's view; master is the producer/consumer side.
interface median_row_packer_if;
  logic [7:0]  in_pixel;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] out_word0;
  logic [31:0] out_word1;
  logic [31:0] out_word2;
  logic        out_valid;
  logic        out_ready;
  logic        out_last;
  logic        primed;

  modport slave (
    input  in_pixel, in_valid, out_ready,
    output in_ready, out_word0, out_word1, out_word2, out_valid, out_last, primed
  );

  modport master (
    output in_pixel, in_valid, out_ready,
    input  in_ready, out_word0, out_word1, out_word2, out_valid, out_last, primed
  );
endinterface

// File: rtl/median_row_packer.sv
// Packs raster pixels into 32-bit words and emits column-aligned row triples (r-2, r-1, r).
// Latency 1 cycle from the completing pixel; in_ready drops only while a held triple is stalled.
module median_row_packer #(
  parameter int LINE_WIDTH = 64,
  parameter int NUM_ROWS   = 64
) (
  input  logic               clk,
  input  logic               rst,
  median_row_packer_if.slave bus
);
  localparam int WPL = LINE_WIDTH / 4;
  localparam int CW  = (WPL > 1) ? $clog2(WPL) : 1;
  localparam int RW  = $clog2(NUM_ROWS);

  logic [1:0]    lane_q, lane_d;
  logic [CW-1:0] col_q, col_d;
  logic [RW-1:0] row_q, row_d;
  logic [23:0]   pend_q, pend_d;
  logic [31:0]   w0_q, w0_d, w1_q, w1_d, w2_q, w2_d;
  logic          vld_q, vld_d, last_q, last_d, primed_q, primed_d;

  logic [31:0]   lb0 [WPL];
  logic [31:0]   lb1 [WPL];

  logic          accept, complete, col_end, row_end;
  logic [31:0]   word_w, rd_a, rd_b;

  assign bus.in_ready  = !vld_q || bus.out_ready;
  assign bus.out_valid = vld_q;
  assign bus.out_last  = last_q;
  assign bus.out_word0 = w0_q;
  assign bus.out_word1 = w1_q;
  assign bus.out_word2 = w2_q;
  assign bus.primed    = primed_q;

  assign accept   = bus.in_valid && bus.in_ready;
  assign complete = accept && (lane_q == 2'd3);
  assign col_end  = (col_q == CW'(WPL - 1));
  assign row_end  = (row_q == RW'(NUM_ROWS - 1));
  assign word_w   = {bus.in_pixel, pend_q};
  // Reads see the previous row's contents; the write lands at the clock edge.
  assign rd_a     = lb0[col_q];
  assign rd_b     = lb1[col_q];

  always_comb begin
    lane_d   = lane_q;
    col_d    = col_q;
    row_d    = row_q;
    pend_d   = pend_q;
    primed_d = primed_q;
    vld_d    = vld_q;
    last_d   = last_q;
    w0_d     = w0_q;
    w1_d     = w1_q;
    w2_d     = w2_q;

    if (accept) begin
      lane_d = lane_q + 2'd1;
      case (lane_q)
        2'd0:    pend_d[7:0]   = bus.in_pixel;
        2'd1:    pend_d[15:8]  = bus.in_pixel;
        2'd2:    pend_d[23:16] = bus.in_pixel;
        default: pend_d        = pend_q;
      endcase
    end

    if (bus.out_ready) begin
      vld_d  = 1'b0;
      last_d = 1'b0;
    end

    if (complete) begin
      col_d = col_end ? '0 : col_q + 1'b1;
      if (col_end) begin
        row_d = row_end ? '0 : row_q + 1'b1;
      end
      if (col_end && (row_q == RW'(1))) begin
        primed_d = 1'b1;
      end
      if (col_end && row_end) begin
        primed_d = 1'b0;
      end
      // A new triple overwrites a draining one in the same cycle, so no bubble.
      if (row_q >= RW'(2)) begin
        vld_d  = 1'b1;
        last_d = col_end && row_end;
        w0_d   = rd_a;
        w1_d   = rd_b;
        w2_d   = word_w;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      lane_q   <= '0;
      col_q    <= '0;
      row_q    <= '0;
      pend_q   <= '0;
      primed_q <= 1'b0;
      vld_q    <= 1'b0;
      last_q   <= 1'b0;
      w0_q     <= '0;
      w1_q     <= '0;
      w2_q     <= '0;
    end else begin
      lane_q   <= lane_d;
      col_q    <= col_d;
      row_q    <= row_d;
      pend_q   <= pend_d;
      primed_q <= primed_d;
      vld_q    <= vld_d;
      last_q   <= last_d;
      w0_q     <= w0_d;
      w1_q     <= w1_d;
      w2_q     <= w2_d;
    end
  end

  // Line buffers carry no reset: contents are never emitted until two fresh rows land.
  always_ff @(posedge clk) begin
    if (complete) begin
      lb0[col_q] <= rd_b;
      lb1[col_q] <= word_w;
    end
  end
endmodule

// File: tb/tb_median_row_packer.sv
// Directed bench for median_row_packer: 8-pixel rows, 4-row frames, pixel = offset + 16*row + col.
module tb_median_row_packer;
  localparam int LW = 8;
  localparam int NR = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad = 0;
  int   vcycles = 0;
  logic [96:0] cap_q [$];

  median_row_packer_if bus ();

  median_row_packer #(.LINE_WIDTH(LW), .NUM_ROWS(NR)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Capture every triple that will transfer at the coming edge.
  always begin
    @(posedge clk);
    #2;
    if (!rst && bus.out_valid === 1'b1) begin
      vcycles++;
      if (bus.out_ready === 1'b1)
        cap_q.push_back({bus.out_last, bus.out_word0, bus.out_word1, bus.out_word2});
    end
  end

  function automatic logic [31:0] expw(input logic [7:0] off, input int r, input int wc);
    logic [31:0] w;
    for (int k = 0; k < 4; k++) w[8*k +: 8] = off + 8'(16 * r + 4 * wc + k);
    return w;
  endfunction

  // Triple i of a frame: rows 2,2,3,3 and word columns 0,1,0,1.
  function automatic logic [96:0] expt(input logic [7:0] off, input int i);
    int r;
    int wc;
    r  = 2 + i / 2;
    wc = i % 2;
    return {(i == 3), expw(off, r - 2, wc), expw(off, r - 1, wc), expw(off, r, wc)};
  endfunction

  task automatic push(input logic [7:0] p, input bit gap);
    bit done;
    if (gap) begin
      bus.in_valid = 1'b0;
      @(posedge clk);
      #1;
    end
    bus.in_pixel = p;
    bus.in_valid = 1'b1;
    done = 1'b0;
    for (int n = 0; n < 200 && !done; n++) begin
      #1;
      if (bus.in_ready === 1'b1) done = 1'b1;
      @(posedge clk);
      #1;
    end
    bus.in_valid = 1'b0;
    if (!done) begin
      total++;
      bad++;
      $display("FAIL push_timeout pixel=%h got in_ready=0 want 1", p);
    end
  endtask

  task automatic send_frame(input logic [7:0] off, input bit rnd);
    for (int r = 0; r < NR; r++)
      for (int c = 0; c < LW; c++)
        push(off + 8'(16 * r + c), rnd ? bit'($urandom_range(0, 1)) : 1'b0);
  endtask

  task automatic start_clean();
    rst = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_pixel = 8'h00;
    bus.out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    cap_q.delete();
    vcycles = 0;
  endtask

  task automatic test_reset();
    start_clean();
    total++;
    if (bus.out_valid !== 1'b0 || bus.out_last !== 1'b0 || bus.primed !== 1'b0) begin
      bad++;
      $display("FAIL reset_flags got v=%b l=%b p=%b want 0 0 0", bus.out_valid, bus.out_last, bus.primed);
    end
    total++;
    if ({bus.out_word0, bus.out_word1, bus.out_word2} !== 96'h0) begin
      bad++;
      $display("FAIL reset_words got=%h want 0", {bus.out_word0, bus.out_word1, bus.out_word2});
    end
    total++;
    if (bus.in_ready !== 1'b1) begin
      bad++;
      $display("FAIL reset_in_ready got=%b want 1", bus.in_ready);
    end
  endtask

  task automatic test_priming();
    start_clean();
    for (int r = 0; r < 2; r++)
      for (int c = 0; c < LW; c++) begin
        push(8'(16 * r + c), 1'b0);
        if (r == 1 && c == 6) begin
          total++;
          if (bus.primed !== 1'b0) begin
            bad++;
            $display("FAIL primed_early got=%b want 0", bus.primed);
          end
        end
      end
    total++;
    if (bus.primed !== 1'b1) begin
      bad++;
      $display("FAIL primed_rise got=%b want 1", bus.primed);
    end
    total++;
    if (vcycles != 0) begin
      bad++;
      $display("FAIL valid_before_row2 got=%0d want 0", vcycles);
    end
    for (int c = 0; c < 4; c++) push(8'h20 + 8'(c), 1'b0);
    total++;
    if (bus.out_valid !== 1'b1 || bus.out_last !== 1'b0) begin
      bad++;
      $display("FAIL first_latency got v=%b l=%b want 1 0", bus.out_valid, bus.out_last);
    end
    total++;
    if ({bus.out_word0, bus.out_word1, bus.out_word2} !== 96'h03020100_13121110_23222120) begin
      bad++;
      $display("FAIL first_triple got=%h want 03020100_13121110_23222120",
               {bus.out_word0, bus.out_word1, bus.out_word2});
    end
  endtask

  task automatic test_frame_contents();
    int lasts;
    start_clean();
    send_frame(8'h00, 1'b0);
    repeat (5) @(posedge clk);
    #1;
    total++;
    if (cap_q.size() != 4) begin
      bad++;
      $display("FAIL frame_count got=%0d want 4", cap_q.size());
    end else begin
      total++;
      if (cap_q[1] !== {1'b0, 96'h07060504_17161514_27262524}) begin
        bad++;
        $display("FAIL triple2 got=%h want 0_07060504_17161514_27262524", cap_q[1]);
      end
      total++;
      if (cap_q[3] !== {1'b1, 96'h17161514_27262524_37363534}) begin
        bad++;
        $display("FAIL triple4_last got=%h want 1_17161514_27262524_37363534", cap_q[3]);
      end
      lasts = 0;
      for (int i = 0; i < 4; i++) if (cap_q[i][96]) lasts++;
      total++;
      if (lasts != 1) begin
        bad++;
        $display("FAIL last_count got=%0d want 1", lasts);
      end
    end
  endtask

  task automatic test_backpressure();
    bit seen;
    logic [96:0] snap;
    start_clean();
    fork
      send_frame(8'h00, 1'b0);
      begin
        seen = 1'b0;
        for (int n = 0; n < 500 && !seen; n++) begin
          @(posedge clk);
          #1;
          if (bus.out_valid === 1'b1) seen = 1'b1;
        end
        total++;
        if (!seen) begin
          bad++;
          $display("FAIL hold_wait_valid got=0 want 1");
        end else begin
          snap = {bus.out_last, bus.out_word0, bus.out_word1, bus.out_word2};
          bus.out_ready = 1'b0;
          for (int k = 0; k < 10; k++) begin
            @(posedge clk);
            #1;
            total++;
            if (bus.out_valid !== 1'b1 ||
                {bus.out_last, bus.out_word0, bus.out_word1, bus.out_word2} !== snap) begin
              bad++;
              $display("FAIL hold_stable cyc=%0d got=%h want=%h", k,
                       {bus.out_last, bus.out_word0, bus.out_word1, bus.out_word2}, snap);
            end
            total++;
            if (bus.in_ready !== 1'b0) begin
              bad++;
              $display("FAIL hold_in_ready cyc=%0d got=%b want 0", k, bus.in_ready);
            end
          end
          bus.out_ready = 1'b1;
        end
      end
    join
    repeat (5) @(posedge clk);
    #1;
    total++;
    if (cap_q.size() != 4) begin
      bad++;
      $display("FAIL hold_count got=%0d want 4", cap_q.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        total++;
        if (cap_q[i] !== expt(8'h00, i)) begin
          bad++;
          $display("FAIL hold_triple%0d got=%h want=%h", i, cap_q[i], expt(8'h00, i));
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    start_clean();
    send_frame(8'h00, 1'b0);
    for (int r = 0; r < 2; r++)
      for (int c = 0; c < LW; c++) push(8'h80 + 8'(16 * r + c), 1'b0);
    total++;
    if (cap_q.size() != 4 || bus.primed !== 1'b1) begin
      bad++;
      $display("FAIL b2b_repriming got count=%0d primed=%b want 4 1", cap_q.size(), bus.primed);
    end
    for (int r = 2; r < NR; r++)
      for (int c = 0; c < LW; c++) push(8'h80 + 8'(16 * r + c), 1'b0);
    repeat (5) @(posedge clk);
    #1;
    total++;
    if (cap_q.size() != 8) begin
      bad++;
      $display("FAIL b2b_count got=%0d want 8", cap_q.size());
    end else begin
      total++;
      if (cap_q[4] !== {1'b0, 96'h83828180_93929190_A3A2A1A0}) begin
        bad++;
        $display("FAIL b2b_first got=%h want 0_83828180_93929190_a3a2a1a0", cap_q[4]);
      end
      for (int i = 0; i < 4; i++) begin
        total++;
        if (cap_q[i] !== expt(8'h00, i) || cap_q[i+4] !== expt(8'h80, i)) begin
          bad++;
          $display("FAIL b2b_triple%0d got=%h/%h want=%h/%h", i, cap_q[i], cap_q[i+4],
                   expt(8'h00, i), expt(8'h80, i));
        end
      end
    end
  endtask

  task automatic test_random_valid();
    int lasts;
    start_clean();
    send_frame(8'h00, 1'b1);
    repeat (5) @(posedge clk);
    #1;
    total++;
    if (cap_q.size() != 4) begin
      bad++;
      $display("FAIL rand_count got=%0d want 4", cap_q.size());
    end else begin
      lasts = 0;
      for (int i = 0; i < 4; i++) begin
        if (cap_q[i][96]) lasts++;
        total++;
        if (cap_q[i] !== expt(8'h00, i)) begin
          bad++;
          $display("FAIL rand_triple%0d got=%h want=%h", i, cap_q[i], expt(8'h00, i));
        end
      end
      total++;
      if (lasts != 1) begin
        bad++;
        $display("FAIL rand_last_count got=%0d want 1", lasts);
      end
    end
  endtask

  task automatic test_mid_reset();
    start_clean();
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < LW; c++)
        if (r < 2 || c <= 5) push(8'(16 * r + c), 1'b0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    total++;
    if (bus.out_valid !== 1'b0 || bus.primed !== 1'b0 || bus.out_last !== 1'b0) begin
      bad++;
      $display("FAIL midrst_flags got v=%b p=%b l=%b want 0 0 0", bus.out_valid, bus.primed, bus.out_last);
    end
    rst = 1'b0;
    cap_q.delete();
    send_frame(8'h00, 1'b0);
    repeat (5) @(posedge clk);
    #1;
    total++;
    if (cap_q.size() != 4) begin
      bad++;
      $display("FAIL midrst_count got=%0d want 4", cap_q.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        total++;
        if (cap_q[i] !== expt(8'h00, i)) begin
          bad++;
          $display("FAIL midrst_triple%0d got=%h want=%h", i, cap_q[i], expt(8'h00, i));
        end
      end
    end
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_pixel  = 8'h00;
    bus.out_ready = 1'b1;
    test_reset();
    test_priming();
    test_frame_contents();
    test_backpressure();
    test_back_to_back();
    test_random_valid();
    test_mid_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog expired");
  end
endmodule
